ga_sync_irq: RTL

GA_SYNC_IRQ -- requirements
Module: ga_sync_irq

---
 rtl/ga_sync_irq.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ga_sync_irq.sv
// Gate-array sync and raster interrupt generator.
// Derives the 52-line interrupt counter (R52), the monitor HSYNC/VSYNC pulses
// and the applied screen mode from the CRTC syncs, stepped by the character clock enable.
// Build option: define GA_MODE_LATCH_EN to apply MODE_IN only at HSYNC rises
// (line boundaries); otherwise MODE_OUT follows MODE_IN with one CLOCK of latency.
module ga_sync_irq (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       CLKEN,
    input  logic       CRTC_HSYNC,
    input  logic       CRTC_VSYNC,
    input  logic       IRQ_ACK,
    input  logic       R52_CLR,
    input  logic [1:0] MODE_IN,
    output logic       INT,
    output logic       HSYNC_OUT,
    output logic       VSYNC_OUT,
    output logic [1:0] MODE_OUT,
    output logic [5:0] R52
);

    typedef enum logic [1:0] {StIdle, StDly, StActive} hs_state_e;

    // Sync history; armed_q stays low for the first CLKEN after reset so an
    // input that is already high is taken as a baseline, not as a rise.
    logic       armed_q;
    logic       hs_q, vs_q;
    logic       hs_rise, hs_end, vs_rise, vs_fall;
    logic       vsync_fire;

    logic [5:0] r52_q, r52_d;
    logic [5:0] r52_inc;
    logic       int_q, int_d;
    logic       set_int;
    logic [1:0] vdly_q, vdly_d;
    logic       vso_q, vso_d;
    logic [1:0] vcnt_q, vcnt_d;
    hs_state_e  state_q, state_d;
    logic [1:0] hcnt_q, hcnt_d;
    logic [1:0] mode_q;

    // Edge detection against the value seen on the previous CLKEN cycle.
    always_comb begin
        hs_rise = CLKEN & armed_q &  CRTC_HSYNC & ~hs_q;
        hs_end  = CLKEN & armed_q & ~CRTC_HSYNC &  hs_q;
        vs_rise = CLKEN & armed_q &  CRTC_VSYNC & ~vs_q;
        vs_fall = CLKEN & armed_q & ~CRTC_VSYNC &  vs_q;
    end

    // The delayed VSYNC takes effect on the second hs_end after a VSYNC rise.
    assign vsync_fire = hs_end & ~vs_rise & (vdly_q == 2'd1);

    // VSYNC delay counter: reload on rise, count hs_end down to zero.
    always_comb begin
        vdly_d = vdly_q;
        if (vs_rise) begin
            vdly_d = 2'd2;
        end else if (hs_end && (vdly_q != 2'd0)) begin
            vdly_d = vdly_q - 2'd1;
        end
    end

    // Line counter and interrupt request; R52_CLR overrides, a new INT beats IRQ_ACK.
    always_comb begin
        r52_d   = r52_q;
        int_d   = int_q;
        set_int = 1'b0;
        r52_inc = r52_q + 6'd1;
        if (hs_end) begin
            if (r52_inc == 6'd52) begin
                r52_d   = 6'd0;
                set_int = 1'b1;
            end else begin
                r52_d = r52_inc;
            end
            if (vsync_fire) begin
                r52_d = 6'd0;
                if (r52_q >= 6'd32) begin
                    set_int = 1'b1;
                end
            end
        end
        if (IRQ_ACK) begin
            r52_d[5] = 1'b0;
            int_d    = 1'b0;
        end
        if (set_int) begin
            int_d = 1'b1;
        end
        if (R52_CLR) begin
            r52_d = 6'd0;
            int_d = 1'b0;
        end
    end

    // Monitor VSYNC: starts at the delayed fire, lasts 4 more hs_end or until CRTC VSYNC falls.
    always_comb begin
        vso_d  = vso_q;
        vcnt_d = vcnt_q;
        if (vs_rise) begin
            vso_d = 1'b0;
        end else if (vsync_fire) begin
            vso_d  = 1'b1;
            vcnt_d = 2'd0;
        end else if (vso_q && vs_fall) begin
            vso_d = 1'b0;
        end else if (vso_q && hs_end) begin
            if (vcnt_q == 2'd3) begin
                vso_d = 1'b0;
            end else begin
                vcnt_d = vcnt_q + 2'd1;
            end
        end
    end

    // Monitor HSYNC FSM: 2-char delay after the rise, then at most 4 chars active.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        if (hs_rise) begin
            state_d = StDly;
            hcnt_d  = 2'd0;
        end else if (hs_end) begin
            state_d = StIdle;
            hcnt_d  = 2'd0;
        end else if (CLKEN) begin
            case (state_q)
                StIdle: begin
                end
                StDly: begin
                    if (hcnt_q == 2'd1) begin
                        state_d = StActive;
                        hcnt_d  = 2'd0;
                    end else begin
                        hcnt_d = hcnt_q + 2'd1;
                    end
                end
                StActive: begin
                    if (hcnt_q == 2'd3) begin
                        state_d = StIdle;
                        hcnt_d  = 2'd0;
                    end else begin
                        hcnt_d = hcnt_q + 2'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    hcnt_d  = 2'd0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            armed_q <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            r52_q   <= 6'd0;
            int_q   <= 1'b0;
            vdly_q  <= 2'd0;
            vso_q   <= 1'b0;
            vcnt_q  <= 2'd0;
            state_q <= StIdle;
            hcnt_q  <= 2'd0;
        end else begin
            if (CLKEN) begin
                armed_q <= 1'b1;
                hs_q    <= CRTC_HSYNC;
                vs_q    <= CRTC_VSYNC;
            end
            r52_q   <= r52_d;
            int_q   <= int_d;
            vdly_q  <= vdly_d;
            vso_q   <= vso_d;
            vcnt_q  <= vcnt_d;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // Applied screen mode.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            mode_q <= 2'd0;
        end else begin
`ifdef GA_MODE_LATCH_EN
            if (hs_rise) begin
                mode_q <= MODE_IN;
            end
`else
            mode_q <= MODE_IN;
`endif
        end
    end

    assign INT       = int_q;
    assign R52       = r52_q;
    assign HSYNC_OUT = (state_q == StActive);
    assign VSYNC_OUT = vso_q;
    assign MODE_OUT  = mode_q;

endmodule
